// File: rtl/vga_rom_sprite_mover_pkg.sv
// Shared constants and types for the VGA ROM sprite source.
// Screen geometry, invalid-pixel marker and RGB565 colours.
package vga_rom_sprite_mover_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

  localparam logic [9:0] PIX_INVALID = 10'h3FF;

  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

endpackage

// File: rtl/vga_rom_sprite_mover_axis.sv
// One-axis position updater for the sprite mover.
// Moves pos by step per frame with bounce or wrap at [0, MAX].
module vga_rom_sprite_mover_axis
  import vga_rom_sprite_mover_pkg::*;
#(
  parameter int MAX  = 540,
  parameter int INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       wrap,
  input  logic [3:0] step,
  output logic [9:0] pos,
  output logic       hit
);

  localparam logic [10:0] MAX_L = 11'(MAX);

  dir_e        dir_q;
  dir_e        dir_n;
  logic [9:0]  pos_n;
  logic        hit_n;
  logic [10:0] cur;
  logic [10:0] stp;
  logic [10:0] sum;
  logic [10:0] dif;

  assign cur = {1'b0, pos};
  assign stp = {7'd0, step};
  assign sum = cur + stp;
  assign dif = cur - stp;

  always_comb begin
    pos_n = pos;
    dir_n = dir_q;
    hit_n = 1'b0;
    if (upd && step != 4'd0) begin
      unique case (1'b1)
        (dir_q == DIR_POS) && wrap: begin
          if (sum > MAX_L) begin
            pos_n = '0;
            hit_n = 1'b1;
          end else begin
            pos_n = 10'(sum);
          end
        end
        (dir_q == DIR_POS) && !wrap: begin
          if (sum >= MAX_L) begin
            pos_n = 10'(MAX);
            dir_n = DIR_NEG;
            hit_n = 1'b1;
          end else begin
            pos_n = 10'(sum);
          end
        end
        (dir_q == DIR_NEG) && wrap: begin
          if (cur < stp) begin
            pos_n = 10'(MAX);
            hit_n = 1'b1;
          end else begin
            pos_n = 10'(dif);
          end
        end
        default: begin
          if (cur <= stp) begin
            pos_n = '0;
            dir_n = DIR_POS;
            hit_n = 1'b1;
          end else begin
            pos_n = 10'(dif);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos   <= 10'(INIT);
      dir_q <= DIR_POS;
      hit   <= 1'b0;
    end else begin
      pos   <= pos_n;
      dir_q <= dir_n;
      hit   <= hit_n;
    end
  end

endmodule

// File: rtl/vga_rom_sprite_mover.sv
// ROM picture source for the VGA pipeline: draws and moves a sprite.
// pix_data follows rom_addr/rom_rd_en by ROM_LAT+1 clocks.
module vga_rom_sprite_mover
  import vga_rom_sprite_mover_pkg::*;
#(
  parameter int          H_VALID  = H_VALID_DEF,
  parameter int          V_VALID  = V_VALID_DEF,
  parameter int          PIC_W    = 100,
  parameter int          PIC_H    = 100,
  parameter int          ADDR_W   = 14,
  parameter int          ROM_LAT  = 1,
  parameter logic [15:0] BG_COLOR = RGB_WHITE,
  parameter int          INIT_X   = 0,
  parameter int          INIT_Y   = 0
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [3:0]        step_x,
  input  logic [3:0]        step_y,
  input  logic              mode_wrap,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [15:0]       rom_data,
  output logic [15:0]       pix_data,
  output logic [9:0]        pic_x,
  output logic [9:0]        pic_y,
  output logic              edge_hit
);

  localparam int MAX_X = H_VALID - PIC_W;
  localparam int MAX_Y = V_VALID - PIC_H;

  logic        frame_tick;
  logic        upd;
  logic        hit_x;
  logic        hit_y;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_x;
  logic        in_y;
  logic        in_pic;
  logic        in_pic_d;

  logic [ROM_LAT-1:0] vld_sh;

  assign frame_tick = (pix_x == 10'(H_VALID - 1)) &&
                      (pix_y == 10'(V_VALID - 1));
  assign upd = frame_tick && !pause;

  vga_rom_sprite_mover_axis #(
    .MAX  (MAX_X),
    .INIT (INIT_X)
  ) u_axis_x (
    .clk  (vga_clk),
    .rst  (sys_rst),
    .upd  (upd),
    .wrap (mode_wrap),
    .step (step_x),
    .pos  (pic_x),
    .hit  (hit_x)
  );

  vga_rom_sprite_mover_axis #(
    .MAX  (MAX_Y),
    .INIT (INIT_Y)
  ) u_axis_y (
    .clk  (vga_clk),
    .rst  (sys_rst),
    .upd  (upd),
    .wrap (mode_wrap),
    .step (step_y),
    .pos  (pic_y),
    .hit  (hit_y)
  );

  assign edge_hit = hit_x | hit_y;

  assign dx = {1'b0, pix_x} - {1'b0, pic_x};
  assign dy = {1'b0, pix_y} - {1'b0, pic_y};

  // Invalid marker is checked explicitly; it could otherwise fall inside a wide picture.
  assign in_x = (pix_x != PIX_INVALID) && (pix_x >= pic_x) &&
                (dx < 11'(PIC_W));
  assign in_y = (pix_y != PIX_INVALID) && (pix_y >= pic_y) &&
                (dy < 11'(PIC_H));
  assign in_pic = in_x && in_y;

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      rom_addr  <= '0;
      rom_rd_en <= 1'b0;
    end else begin
      rom_rd_en <= in_pic;
      if (in_pic) begin
        rom_addr <= ADDR_W'(dy) * ADDR_W'(PIC_W) + ADDR_W'(dx);
      end
    end
  end

  generate
    if (ROM_LAT == 1) begin : g_lat1
      always_ff @(posedge vga_clk) begin
        if (sys_rst) vld_sh <= '0;
        else         vld_sh <= rom_rd_en;
      end
    end else begin : g_latn
      always_ff @(posedge vga_clk) begin
        if (sys_rst) vld_sh <= '0;
        else         vld_sh <= {vld_sh[ROM_LAT-2:0], rom_rd_en};
      end
    end
  endgenerate

  assign in_pic_d = vld_sh[ROM_LAT-1];

  always_ff @(posedge vga_clk) begin
    if (sys_rst) pix_data <= RGB_BLACK;
    else         pix_data <= in_pic_d ? rom_data : BG_COLOR;
  end

endmodule

// File: tb/tb_vga_rom_sprite_mover.sv
// Directed bench for vga_rom_sprite_mover.
// Drives pix_x/pix_y directly and models a 1-clock picture ROM.
module tb_vga_rom_sprite_mover;

  localparam logic [9:0] INV = 10'h3FF;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [3:0]  step_x;
  logic [3:0]  step_y;
  logic        mode_wrap;
  logic        pause;
  logic [13:0] rom_addr;
  logic        rom_rd_en;
  logic [15:0] rom_data = '0;
  logic [15:0] pix_data;
  logic [9:0]  pic_x;
  logic [9:0]  pic_y;
  logic        edge_hit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_rom_sprite_mover dut (
    .vga_clk   (clk),
    .sys_rst   (sys_rst),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .step_x    (step_x),
    .step_y    (step_y),
    .mode_wrap (mode_wrap),
    .pause     (pause),
    .rom_addr  (rom_addr),
    .rom_rd_en (rom_rd_en),
    .rom_data  (rom_data),
    .pix_data  (pix_data),
    .pic_x     (pic_x),
    .pic_y     (pic_y),
    .edge_hit  (edge_hit)
  );

  function automatic logic [15:0] rom_fn(input logic [13:0] a);
    return {2'b00, a} ^ 16'hC35A;
  endfunction

  always @(posedge clk) begin
    if (rom_rd_en) rom_data <= rom_fn(rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic exp_hit);
    pix_x = 10'd639;
    pix_y = 10'd479;
    @(posedge clk); #1;
    pix_x = INV;
    pix_y = INV;
    chk("edge_hit", 32'(edge_hit), 32'(exp_hit));
    if (exp_hit) begin
      @(posedge clk); #1;
      chk("hit_pulse", 32'(edge_hit), 32'd0);
    end
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y,
                       input logic en, input logic [13:0] addr,
                       input logic [15:0] pix);
    pix_x = x;
    pix_y = y;
    @(posedge clk); #1;
    pix_x = INV;
    pix_y = INV;
    chk("rd_en", 32'(rom_rd_en), 32'(en));
    chk("rom_addr", 32'(rom_addr), 32'(addr));
    repeat (2) @(posedge clk);
    #1;
    chk("pix_data", 32'(pix_data), 32'(pix));
  endtask

  initial begin
    sys_rst   = 1'b1;
    pix_x     = INV;
    pix_y     = INV;
    step_x    = 4'd0;
    step_y    = 4'd0;
    mode_wrap = 1'b0;
    pause     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pic_x", 32'(pic_x), 32'd0);
    chk("rst_pic_y", 32'(pic_y), 32'd0);
    chk("rst_rd_en", 32'(rom_rd_en), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix", 32'(pix_data), 32'd0);
    chk("rst_hit", 32'(edge_hit), 32'd0);
    sys_rst = 1'b0;

    probe(10'd0, 10'd0, 1'b1, 14'd0, rom_fn(14'd0));
    probe(10'd5, 10'd3, 1'b1, 14'd305, rom_fn(14'd305));

    step_x = 4'd10;
    for (int i = 0; i < 10; i++) tick(1'b0);
    chk("mv_pic_x", 32'(pic_x), 32'd100);
    chk("hold_pic_y", 32'(pic_y), 32'd0);

    probe(10'd150, 10'd20, 1'b1, 14'd2050, rom_fn(14'd2050));
    probe(10'd200, 10'd20, 1'b0, 14'd2050, 16'hFFFF);
    probe(10'd99, 10'd20, 1'b0, 14'd2050, 16'hFFFF);
    probe(10'd199, 10'd99, 1'b1, 14'd9999, rom_fn(14'd9999));
    probe(INV, 10'd20, 1'b0, 14'd9999, 16'hFFFF);
    probe(10'd150, 10'd100, 1'b0, 14'd9999, 16'hFFFF);

    pause  = 1'b1;
    step_y = 4'd10;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk("pause_x", 32'(pic_x), 32'd100);
      chk("pause_y", 32'(pic_y), 32'd0);
    end
    pause = 1'b0;

    for (int i = 0; i < 20; i++) tick(1'b0);
    chk("pos_x300", 32'(pic_x), 32'd300);
    chk("pos_y200", 32'(pic_y), 32'd200);

    pix_x = 10'd320;
    pix_y = 10'd250;
    @(posedge clk); #1;
    chk("pre_rst_en", 32'(rom_rd_en), 32'd1);
    sys_rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_pic_x", 32'(pic_x), 32'd0);
    chk("mrst_pic_y", 32'(pic_y), 32'd0);
    chk("mrst_pix", 32'(pix_data), 32'd0);
    chk("mrst_rd_en", 32'(rom_rd_en), 32'd0);
    sys_rst = 1'b0;
    pix_x   = INV;
    pix_y   = INV;

    mode_wrap = 1'b0;
    step_y    = 4'd0;
    step_x    = 4'd15;
    for (int i = 0; i < 35; i++) tick(1'b0);
    step_x = 4'd13;
    tick(1'b0);
    chk("b_538", 32'(pic_x), 32'd538);
    step_x = 4'd4;
    tick(1'b1);
    chk("b_540", 32'(pic_x), 32'd540);
    tick(1'b0);
    chk("b_536", 32'(pic_x), 32'd536);

    mode_wrap = 1'b1;
    step_x    = 4'd15;
    for (int i = 0; i < 35; i++) tick(1'b0);
    step_x = 4'd9;
    tick(1'b0);
    chk("w_2", 32'(pic_x), 32'd2);
    step_x = 4'd4;
    tick(1'b1);
    chk("w_540", 32'(pic_x), 32'd540);
    tick(1'b0);
    chk("w_536", 32'(pic_x), 32'd536);

    step_x = 4'd0;
    step_y = 4'd15;
    for (int i = 0; i < 25; i++) tick(1'b0);
    step_y = 4'd5;
    tick(1'b0);
    chk("wy_380", 32'(pic_y), 32'd380);
    step_y = 4'd1;
    tick(1'b1);
    chk("wy_0", 32'(pic_y), 32'd0);
    chk("hold_x", 32'(pic_x), 32'd536);

    mode_wrap = 1'b0;
    step_y    = 4'd15;
    for (int i = 0; i < 25; i++) tick(1'b0);
    step_y = 4'd5;
    tick(1'b1);
    chk("by_380", 32'(pic_y), 32'd380);
    step_y = 4'd10;
    tick(1'b0);
    chk("by_370", 32'(pic_y), 32'd370);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
